// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
//   ps2_state_e : frame FSM state encoding
//   ps2_entry_t : FIFO entry {ext, brk, code}
//   PS2_EXT_PREFIX / PS2_BRK_PREFIX : prefix bytes folded into flags
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
  localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_entry_t;

endpackage

// File: rtl/ps2_rx_fifo.sv
// First-word-fall-through FIFO for decoded scan-code entries.
// Ports:
//   clock, reset   : system clock, async active-high reset
//   push, wr_data  : write request and 10-bit entry {ext, brk, code}
//   pop            : read request, ignored while empty
//   rd_data        : registered head entry (zero while empty)
//   valid, full    : registered occupancy flags after the current edge
//   overflow       : 1-cycle pulse when a push is dropped
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic [9:0] wr_data,
  input  logic       pop,
  output logic [9:0] rd_data,
  output logic       valid,
  output logic       full,
  output logic       overflow
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  ps2_entry_t    mem_q [DEPTH];
  ps2_entry_t    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          valid_q, valid_d;
  logic          full_q, full_d;
  logic          ovf_q, ovf_d;
  ps2_entry_t    head_q, head_d;
  logic          pop_ok_c, push_ok_c;

  // Next-state: a pop frees the slot a simultaneous push needs when full.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    pop_ok_c  = pop & valid_q;
    push_ok_c = push & (~full_q | pop_ok_c);
    ovf_d     = push & full_q & ~pop_ok_c;

    if (push_ok_c) begin
      mem_d[wr_ptr_q] = ps2_entry_t'(wr_data);
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok_c) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({push_ok_c, pop_ok_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    valid_d = (count_d != '0);
    full_d  = (count_d == CW'(DEPTH));
    head_d  = valid_d ? mem_d[rd_ptr_d] : '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      head_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
      head_q   <= head_d;
    end
  end

  assign rd_data  = head_q;
  assign valid    = valid_q;
  assign full     = full_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/ps2_rx_decoder.sv
// PS/2 keyboard receiver in the system clock domain: synchronises and
// deglitches the pad signals, deframes 11-bit odd-parity frames, folds
// E0/F0 prefixes into flags and queues results in a FWFT FIFO.
// Optional macro PS2_RX_TIMEOUT_EN builds an intra-frame timeout.
// Ports:
//   clock, reset        : system clock, async active-high reset
//   ps2c, ps2d          : raw PS/2 clock/data pads
//   rd_en               : pop FIFO head
//   code_valid, code    : FIFO not empty, head scan code
//   is_break, is_ext    : head entry prefix flags
//   fifo_full, overflow : FIFO full, dropped-code pulse
//   parity_err, frame_err, timeout_err : 1-cycle error pulses
module ps2_rx_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2c,
  input  logic       ps2d,
  input  logic       rd_en,
  output logic       code_valid,
  output logic [7:0] code,
  output logic       is_break,
  output logic       is_ext,
  output logic       fifo_full,
  output logic       overflow,
  output logic       parity_err,
  output logic       frame_err,
  output logic       timeout_err
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);

  logic          c_meta_q, c_sync_q, d_meta_q, d_sync_q;
  logic          c_filt_q, c_filt_d;
  logic          c_prev_q, c_prev_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          fall_tick_q, fall_tick_d;

  ps2_state_e    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          ok_q, ok_d;
  logic          byte_done_q, byte_done_d;
  logic          par_err_q, par_err_d;
  logic          frm_err_q, frm_err_d;
  logic          to_err_q, to_err_d;
  logic          ext_pend_q, ext_pend_d;
  logic          brk_pend_q, brk_pend_d;
  logic          to_hit_c;
  logic          push_c;
  ps2_entry_t    push_entry_c;
  ps2_entry_t    head_c;

  // Two-flop synchronisers, idle-high at reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      c_meta_q <= 1'b1;
      c_sync_q <= 1'b1;
      d_meta_q <= 1'b1;
      d_sync_q <= 1'b1;
    end else begin
      c_meta_q <= ps2c;
      c_sync_q <= c_meta_q;
      d_meta_q <= ps2d;
      d_sync_q <= d_meta_q;
    end
  end

  // Clock filter: level changes after FILTER_LEN consecutive differing samples.
  always_comb begin
    c_filt_d   = c_filt_q;
    filt_cnt_d = '0;
    if (c_sync_q != c_filt_q) begin
      if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
        c_filt_d = c_sync_q;
      end else begin
        filt_cnt_d = filt_cnt_q + FW'(1);
      end
    end
    c_prev_d    = c_filt_q;
    fall_tick_d = c_prev_q & ~c_filt_q;
  end

`ifdef PS2_RX_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;

  // Idle-time counter between falls while a frame is open.
  always_comb begin
    to_cnt_d = to_cnt_q + TW'(1);
    to_hit_c = 1'b0;
    if (fall_tick_q || (state_q == ST_IDLE)) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
      to_hit_c = 1'b1;
      to_cnt_d = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) to_cnt_q <= '0;
    else       to_cnt_q <= to_cnt_d;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
  assign to_hit_c           = 1'b0;
`endif

  // Frame FSM; every transition is qualified by fall_tick.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    ok_d        = ok_q;
    byte_done_d = 1'b0;
    par_err_d   = 1'b0;
    frm_err_d   = 1'b0;
    to_err_d    = 1'b0;

    if (fall_tick_q) begin
      case (state_q)
        ST_IDLE: begin
          if (!d_sync_q) begin
            state_d   = ST_DATA;
            bit_cnt_d = 3'd0;
          end else begin
            frm_err_d = 1'b1;
          end
        end
        ST_DATA: begin
          shreg_d = {d_sync_q, shreg_q[7:1]};
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
          else                   bit_cnt_d = bit_cnt_q + 3'd1;
        end
        ST_PARITY: begin
          ok_d    = ^{shreg_q, d_sync_q};
          state_d = ST_STOP;
        end
        ST_STOP: begin
          if (!d_sync_q)  frm_err_d   = 1'b1;
          else if (ok_q)  byte_done_d = 1'b1;
          else            par_err_d   = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (to_hit_c) begin
      state_d  = ST_IDLE;
      to_err_d = 1'b1;
    end
  end

  // Prefix folding: prefixes only set flags; errors and pushes clear them.
  always_comb begin
    ext_pend_d = ext_pend_q;
    brk_pend_d = brk_pend_q;
    push_c     = 1'b0;
    if (par_err_q || frm_err_q || to_err_q) begin
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
    end else if (byte_done_q) begin
      if (shreg_q == PS2_EXT_PREFIX) begin
        ext_pend_d = 1'b1;
      end else if (shreg_q == PS2_BRK_PREFIX) begin
        brk_pend_d = 1'b1;
      end else begin
        push_c     = 1'b1;
        ext_pend_d = 1'b0;
        brk_pend_d = 1'b0;
      end
    end
  end

  assign push_entry_c = {ext_pend_q, brk_pend_q, shreg_q};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      c_filt_q    <= 1'b1;
      c_prev_q    <= 1'b1;
      filt_cnt_q  <= '0;
      fall_tick_q <= 1'b0;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      shreg_q     <= 8'd0;
      ok_q        <= 1'b0;
      byte_done_q <= 1'b0;
      par_err_q   <= 1'b0;
      frm_err_q   <= 1'b0;
      to_err_q    <= 1'b0;
      ext_pend_q  <= 1'b0;
      brk_pend_q  <= 1'b0;
    end else begin
      c_filt_q    <= c_filt_d;
      c_prev_q    <= c_prev_d;
      filt_cnt_q  <= filt_cnt_d;
      fall_tick_q <= fall_tick_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      ok_q        <= ok_d;
      byte_done_q <= byte_done_d;
      par_err_q   <= par_err_d;
      frm_err_q   <= frm_err_d;
      to_err_q    <= to_err_d;
      ext_pend_q  <= ext_pend_d;
      brk_pend_q  <= brk_pend_d;
    end
  end

  ps2_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push_c),
    .wr_data  (push_entry_c),
    .pop      (rd_en),
    .rd_data  (head_c),
    .valid    (code_valid),
    .full     (fifo_full),
    .overflow (overflow)
  );

  assign code        = head_c.code;
  assign is_break    = head_c.brk;
  assign is_ext      = head_c.ext;
  assign parity_err  = par_err_q;
  assign frame_err   = frm_err_q;
  assign timeout_err = to_err_q;

endmodule
